// File: rtl/dplca_txop_table.sv
// DPLCA TXOP claim table: records active TXOPs, ages the table every aging_cycles BEACON-delimited cycles.
// Optional build macro DPLCA_AGE_STATS_EN adds o_age_windows and o_claim_count.
module dplca_txop_table #(
  parameter int ID_W    = 8,
  parameter int TABLE_W = 256,
  parameter int AGE_W   = 16
) (
  input  logic               i_clk,
  input  logic               i_plca_reset_n,
  input  logic               i_dplca_aging,
  input  logic [1:0]         i_rx_cmd,
  input  logic               i_txop_done,
  input  logic [ID_W-1:0]    i_txop_id,
  input  logic               i_txop_active,
  input  logic [ID_W-1:0]    i_plca_node_count,
  input  logic [AGE_W-1:0]   i_aging_cycles,
  output logic [TABLE_W-1:0] o_txop_claim_table,
  output logic               o_dplca_txop_table_upd,
  output logic [ID_W-1:0]    o_dplca_txop_id,
  output logic [ID_W-1:0]    o_dplca_txop_node_count,
  output logic               o_dplca_new_age,
  output logic [ID_W-1:0]    o_max_claim
`ifdef DPLCA_AGE_STATS_EN
  ,
  output logic [15:0]        o_age_windows,
  output logic [ID_W:0]      o_claim_count
`endif
);

  // state   | meaning
  // S_IDLE  | aging off; counter held at 0, claims still recorded
  // S_COUNT | counting beacon edges toward the aging boundary
  // S_AGE   | one-cycle boundary; snapshot already taken on entry
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_AGE   = 2'd2
  } state_t;

  localparam logic [1:0] CMD_BEACON = 2'b00;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_beacon_d;
  logic [AGE_W-1:0]     r_cycle_cnt;
  logic [TABLE_W-1:0]   r_work;

  logic                 w_beacon_edge;
  logic                 w_thresh;
  logic                 w_enter_age;
  logic                 w_accept;
  logic [AGE_W:0]       w_cnt_p1;
  logic [AGE_W-1:0]     w_cnt_sat;
  logic [TABLE_W-1:0]   w_claim_bit;
  logic [TABLE_W-1:0]   w_work_nxt;
  logic [TABLE_W-1:0]   w_table_nxt;
  logic [ID_W-1:0]      w_max;

  assign w_beacon_edge = (i_rx_cmd == CMD_BEACON) && !r_beacon_d;
  assign w_cnt_p1      = {1'b0, r_cycle_cnt} + {{AGE_W{1'b0}}, 1'b1};
  assign w_cnt_sat     = (&r_cycle_cnt) ? r_cycle_cnt : w_cnt_p1[AGE_W-1:0];
  assign w_thresh      = (|i_aging_cycles) && (w_cnt_p1 >= {1'b0, i_aging_cycles});
  assign w_accept      = i_txop_done && (i_txop_id < i_plca_node_count);
  assign w_claim_bit   = (w_accept && i_txop_active) ?
                         ({{(TABLE_W-1){1'b0}}, 1'b1} << i_txop_id) : '0;

  // A claim landing on the boundary edge goes into both the snapshot and the fresh working table.
  assign w_work_nxt    = (w_enter_age ? '0 : r_work) | w_claim_bit;
  assign w_table_nxt   = (w_enter_age ? r_work : o_txop_claim_table) | w_claim_bit;

  always_ff @(posedge i_clk) begin
    if (!i_plca_reset_n) r_state <= S_IDLE;
    else                 r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_dplca_aging) w_state_nxt = S_COUNT;
      S_COUNT: if (w_beacon_edge && w_thresh) w_state_nxt = S_AGE;
      S_AGE:   w_state_nxt = S_COUNT;
      default: w_state_nxt = S_IDLE;
    endcase
    if (!i_dplca_aging) w_state_nxt = S_IDLE;
  end

  always_comb begin
    o_dplca_new_age = (r_state == S_AGE);
    w_enter_age     = (r_state == S_COUNT) && (w_state_nxt == S_AGE);
  end

  // Reset value 1 hides a BEACON already held when reset releases.
  always_ff @(posedge i_clk) begin
    if (!i_plca_reset_n) r_beacon_d <= 1'b1;
    else                 r_beacon_d <= (i_rx_cmd == CMD_BEACON);
  end

  always_ff @(posedge i_clk) begin
    if (!i_plca_reset_n) begin
      r_cycle_cnt <= '0;
    end else begin
      case (r_state)
        S_COUNT: begin
          if (w_enter_age)        r_cycle_cnt <= '0;
          else if (w_beacon_edge) r_cycle_cnt <= w_cnt_sat;
        end
        default: r_cycle_cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_plca_reset_n) begin
      r_work                  <= '0;
      o_txop_claim_table      <= '0;
      o_dplca_txop_table_upd  <= 1'b0;
      o_dplca_txop_id         <= '0;
      o_dplca_txop_node_count <= '0;
    end else begin
      r_work                  <= w_work_nxt;
      o_txop_claim_table      <= w_table_nxt;
      o_dplca_txop_table_upd  <= w_accept;
      if (w_accept) begin
        o_dplca_txop_id         <= i_txop_id;
        o_dplca_txop_node_count <= i_plca_node_count;
      end
    end
  end

  // Encoding the next table keeps o_max_claim aligned with the upd/new_age pulses.
  always_comb begin
    w_max = '0;
    for (int i = 0; i < TABLE_W; i++) begin
      if (w_table_nxt[i]) w_max = ID_W'(i);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_plca_reset_n) o_max_claim <= '0;
    else                 o_max_claim <= w_max;
  end

`ifdef DPLCA_AGE_STATS_EN
  always_ff @(posedge i_clk) begin
    if (!i_plca_reset_n) begin
      o_age_windows <= '0;
      o_claim_count <= '0;
    end else begin
      if (w_enter_age && !(&o_age_windows)) o_age_windows <= o_age_windows + 16'd1;
      o_claim_count <= (ID_W+1)'($countones(w_table_nxt));
    end
  end
`endif

endmodule

// File: tb/tb_dplca_txop_table.sv
// Scoreboard bench for dplca_txop_table: driver runs a spec-level model and queues expected events.
module tb_dplca_txop_table;

  localparam logic [1:0] BEACON = 2'b00;
  localparam logic [1:0] COMMIT = 2'b01;
  localparam logic [1:0] NONE   = 2'b10;

  logic         clk = 1'b0;
  logic         plca_reset_n;
  logic         dplca_aging;
  logic [1:0]   rx_cmd;
  logic         txop_done;
  logic [7:0]   txop_id;
  logic         txop_active;
  logic [7:0]   plca_node_count;
  logic [15:0]  aging_cycles;
  logic [255:0] claim_table;
  logic         upd;
  logic [7:0]   out_id;
  logic [7:0]   out_nc;
  logic         new_age;
  logic [7:0]   max_claim;
`ifdef DPLCA_AGE_STATS_EN
  logic [15:0]  age_windows;
  logic [8:0]   claim_count;
`endif

  dplca_txop_table dut (
    .i_clk                   (clk),
    .i_plca_reset_n          (plca_reset_n),
    .i_dplca_aging           (dplca_aging),
    .i_rx_cmd                (rx_cmd),
    .i_txop_done             (txop_done),
    .i_txop_id               (txop_id),
    .i_txop_active           (txop_active),
    .i_plca_node_count       (plca_node_count),
    .i_aging_cycles          (aging_cycles),
    .o_txop_claim_table      (claim_table),
    .o_dplca_txop_table_upd  (upd),
    .o_dplca_txop_id         (out_id),
    .o_dplca_txop_node_count (out_nc),
    .o_dplca_new_age         (new_age),
    .o_max_claim             (max_claim)
`ifdef DPLCA_AGE_STATS_EN
    ,
    .o_age_windows           (age_windows),
    .o_claim_count           (claim_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    logic         upd;
    logic         age;
    logic [7:0]   id;
    logic [7:0]   nc;
    logic [255:0] tbl;
    logic [7:0]   mx;
    logic [15:0]  aw;
    logic [8:0]   cc;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state
  logic [255:0] m_work, m_table;
  logic [7:0]   m_id, m_nc;
  int           m_cnt, m_aw;
  logic         m_prev_bcn, m_prev_aging, m_prev_boundary;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] hi_idx(logic [255:0] t);
    logic [7:0] r = '0;
    for (int i = 0; i < 256; i++) if (t[i]) r = 8'(i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].cyc == cyc) begin
      e_mon = q.pop_front();
      if (!(upd || new_age)) begin
        n_checks++;
        n_errors++;
        $display("FAIL missing_event: cycle %0d no upd/new_age, expected upd=%0b new_age=%0b",
                 cyc, e_mon.upd, e_mon.age);
      end else begin
        chk("upd", 256'(upd), 256'(e_mon.upd));
        chk("new_age", 256'(new_age), 256'(e_mon.age));
        chk("txop_id", 256'(out_id), 256'(e_mon.id));
        chk("node_count", 256'(out_nc), 256'(e_mon.nc));
        chk("claim_table", claim_table, e_mon.tbl);
        chk("max_claim", 256'(max_claim), 256'(e_mon.mx));
`ifdef DPLCA_AGE_STATS_EN
        chk("age_windows", 256'(age_windows), 256'(e_mon.aw));
        chk("claim_count", 256'(claim_count), 256'(e_mon.cc));
`endif
      end
    end else if (upd || new_age) begin
      n_checks++;
      n_errors++;
      $display("FAIL spurious_event: cycle %0d upd=%0b new_age=%0b, expected neither", cyc, upd, new_age);
    end
  end

  task automatic model_reset();
    m_work = '0; m_table = '0; m_id = '0; m_nc = '0;
    m_cnt = 0; m_aw = 0;
    m_prev_bcn = 1'b1; m_prev_aging = 1'b0; m_prev_boundary = 1'b0;
  endtask

  // One clock: apply inputs, advance the model, queue the event expected next cycle.
  task automatic step(input logic [1:0] cmd, input logic done, input logic [7:0] id, input logic act);
    logic edge_b, counting, boundary, accept;
    logic [255:0] cb;
    exp_t e;
    rx_cmd = cmd; txop_done = done; txop_id = id; txop_active = act;
    edge_b   = (cmd == BEACON) && !m_prev_bcn;
    counting = m_prev_aging && !m_prev_boundary;
    boundary = counting && dplca_aging && edge_b && (aging_cycles != 0) &&
               (m_cnt + 1 >= int'(aging_cycles));
    accept   = done && (id < plca_node_count);
    cb = '0;
    if (accept && act) cb[id] = 1'b1;
    if (boundary) begin
      m_table = m_work | cb;
      m_work  = cb;
      if (m_aw < 65535) m_aw++;
    end else begin
      m_table = m_table | cb;
      m_work  = m_work | cb;
    end
    if (!counting || boundary) m_cnt = 0;
    else if (edge_b && m_cnt < 65535) m_cnt++;
    if (accept) begin
      m_id = id;
      m_nc = plca_node_count;
    end
    if (accept || boundary) begin
      e.cyc = cyc + 1; e.upd = accept; e.age = boundary; e.id = m_id; e.nc = m_nc;
      e.tbl = m_table; e.mx = hi_idx(m_table); e.aw = 16'(m_aw); e.cc = 9'($countones(m_table));
      q.push_back(e);
    end
    m_prev_bcn = (cmd == BEACON);
    m_prev_aging = dplca_aging;
    m_prev_boundary = boundary;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    plca_reset_n = 1'b0;
    txop_done = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    plca_reset_n = 1'b1;
    model_reset();
  endtask

  task automatic idle(input int n);
    repeat (n) step(NONE, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic bcn(input int gap);
    step(BEACON, 1'b0, 8'd0, 1'b0);
    idle(gap);
  endtask

  task automatic claim(input logic [7:0] id, input logic act);
    step(NONE, 1'b1, id, act);
  endtask

  initial begin
    plca_reset_n = 1'b0; dplca_aging = 1'b0; rx_cmd = NONE; txop_done = 1'b0;
    txop_id = '0; txop_active = 1'b0; plca_node_count = 8'd8; aging_cycles = 16'd4;
    model_reset();
    do_reset(3);

    // Build 0x0F mid-window, then reset with BEACON held across release.
    dplca_aging = 1'b1;
    idle(2);
    bcn(2);
    for (int i = 0; i < 4; i++) claim(8'(i), 1'b1);
    bcn(1);
    rx_cmd = BEACON;
    aging_cycles = 16'd1;
    do_reset(2);
    @(negedge clk);
    chk("reset_table", claim_table, '0);
    chk("reset_upd", 256'(upd), '0);
    chk("reset_new_age", 256'(new_age), '0);
    chk("reset_id", 256'(out_id), '0);
    chk("reset_nc", 256'(out_nc), '0);
    chk("reset_max", 256'(max_claim), '0);
`ifdef DPLCA_AGE_STATS_EN
    chk("reset_age_windows", 256'(age_windows), '0);
    chk("reset_claim_count", 256'(claim_count), '0);
`endif
    repeat (4) step(BEACON, 1'b0, 8'd0, 1'b0);
    idle(2);

    // Aging scenario with claim accept, out-of-range id and claim on the boundary edge.
    do_reset(1);
    plca_node_count = 8'd8; aging_cycles = 16'd4; dplca_aging = 1'b1;
    idle(2);
    claim(8'd3, 1'b1);
    claim(8'd1, 1'b1);
    claim(8'd5, 1'b1);
    repeat (4) bcn(2);
    claim(8'd5, 1'b1);
    claim(8'd9, 1'b1);
    claim(8'd6, 1'b0);
    repeat (4) bcn(2);
    chk("window2_table", claim_table, 256'h20);
    chk("window2_max", 256'(max_claim), 256'd5);
    repeat (3) bcn(2);
    step(BEACON, 1'b1, 8'd2, 1'b1);
    idle(2);
    repeat (4) bcn(2);
    chk("retained_table", claim_table, 256'h04);
    chk("retained_max", 256'(max_claim), 256'd2);

    // Aging disabled: no boundary however many beacons arrive.
    aging_cycles = 16'd0;
    repeat (300) bcn(1);

`ifdef DPLCA_AGE_STATS_EN
    do_reset(1);
    aging_cycles = 16'd1; dplca_aging = 1'b1;
    idle(2);
    repeat (3) bcn(2);
    chk("age_windows_3", 256'(age_windows), 256'd3);
`endif

    // Randomized traffic.
    for (int blk = 0; blk < 16; blk++) begin
      int lim;
      plca_node_count = (blk % 3 == 0) ? 8'd8 : 8'($urandom_range(1, 255));
      aging_cycles = 16'($urandom_range(0, 5));
      dplca_aging = ($urandom_range(0, 3) != 0);
      lim = int'(plca_node_count) + 4;
      if (lim > 255) lim = 255;
      if (blk == 9) do_reset(1);
      for (int c = 0; c < 200; c++) begin
        logic [1:0] cmd;
        int r = $urandom_range(0, 5);
        cmd = (r == 0) ? BEACON : ((r == 1) ? COMMIT : NONE);
        step(cmd, ($urandom_range(0, 2) == 0), 8'($urandom_range(0, lim)), 1'($urandom_range(0, 1)));
      end
    end

    idle(3);
    chk("queue_drained", 256'(q.size()), '0);
    chk("final_table", claim_table, m_table);
    chk("final_max", 256'(max_claim), 256'(hi_idx(m_table)));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
